// File: rtl/snax_mac_pack_package.sv
// Shared types and constants for the MAC result packer.
// Holds the packer FSM encoding and the byte-strobe width helper.
package snax_mac_pack_package;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PACK  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } pack_state_e;

  localparam int unsigned BYTE_WIDTH = 8;

  // One strobe bit per byte of the packed output beat.
  function automatic int unsigned strb_width(input int unsigned data_width,
                                             input int unsigned pack);
    return (data_width * pack) / BYTE_WIDTH;
  endfunction

endpackage

// File: rtl/snax_mac_result_packer.sv
// Packs PACK engine result words into one wide beat for the TCDM write streamer.
// Latency: beat valid 1 cycle after the handshake of its last word.
// Backpressure: d_ready_o drops while a held beat is not accepted downstream.
module snax_mac_result_packer
  import snax_mac_pack_package::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned PACK       = 2,
  parameter int unsigned LEN_WIDTH  = 16
) (
  input  logic                                     clk_i,
  input  logic                                     rst_i,
  input  logic                                     clear_i,
  input  logic                                     start_i,
  input  logic [LEN_WIDTH-1:0]                     len_i,
  input  logic                                     d_valid_i,
  output logic                                     d_ready_o,
  input  logic [DATA_WIDTH-1:0]                    d_data_i,
  output logic                                     o_valid_o,
  input  logic                                     o_ready_i,
  output logic [DATA_WIDTH*PACK-1:0]               o_data_o,
  output logic [strb_width(DATA_WIDTH, PACK)-1:0]  o_strb_o,
  output logic                                     busy_o,
  output logic                                     done_o,
  output logic [LEN_WIDTH-1:0]                     beats_o
);

  localparam int unsigned STRB_W = strb_width(DATA_WIDTH, PACK);
  localparam int unsigned LANE_B = DATA_WIDTH / BYTE_WIDTH;
  localparam int unsigned IDX_W  = $clog2(PACK);

  pack_state_e state_q, state_d;

  logic [LEN_WIDTH-1:0]       remaining_q;
  logic [IDX_W-1:0]           lane_q;
  logic [DATA_WIDTH*PACK-1:0] acc_q;
  logic [DATA_WIDTH*PACK-1:0] o_data_q;
  logic [STRB_W-1:0]          o_strb_q;
  logic                       o_valid_q;
  logic [LEN_WIDTH-1:0]       beats_q;

  logic                       d_fire;
  logic                       o_fire;
  logic                       last_word;
  logic                       beat_end;
  logic [DATA_WIDTH*PACK-1:0] beat_data;
  logic [STRB_W-1:0]          beat_strb;

  // A word may enter only if the output slot is empty or emptying this cycle.
  assign d_ready_o = (state_q == ST_PACK) && (!o_valid_q || o_ready_i) && !clear_i;
  assign d_fire    = d_valid_i && d_ready_o;
  assign o_fire    = o_valid_q && o_ready_i && !clear_i;
  assign last_word = (remaining_q == LEN_WIDTH'(1));
  assign beat_end  = d_fire && ((lane_q == IDX_W'(PACK - 1)) || last_word);

  // Accumulator lanes beyond the current index are always zero, so a
  // short final beat comes out zero-padded without extra masking.
  always_comb begin
    beat_data = acc_q;
    beat_strb = '0;
    for (int k = 0; k < int'(PACK); k++) begin
      if (lane_q == IDX_W'(k)) begin
        beat_data[k*DATA_WIDTH +: DATA_WIDTH] = d_data_i;
      end
      if (IDX_W'(k) <= lane_q) begin
        beat_strb[k*LANE_B +: LANE_B] = {LANE_B{1'b1}};
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = (len_i != '0) ? ST_PACK : ST_DONE;
        end
      end
      ST_PACK: begin
        if (d_fire && last_word) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (o_fire) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (clear_i) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      lane_q      <= '0;
      acc_q       <= '0;
      o_data_q    <= '0;
      o_strb_q    <= '0;
      o_valid_q   <= 1'b0;
      beats_q     <= '0;
    end else if (clear_i) begin
      state_q   <= ST_IDLE;
      lane_q    <= '0;
      acc_q     <= '0;
      o_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if ((state_q == ST_IDLE) && start_i) begin
        remaining_q <= len_i;
        lane_q      <= '0;
        acc_q       <= '0;
        beats_q     <= '0;
      end
      if (o_fire) begin
        beats_q <= beats_q + LEN_WIDTH'(1);
      end
      if (d_fire) begin
        remaining_q <= remaining_q - LEN_WIDTH'(1);
        if (beat_end) begin
          acc_q     <= '0;
          lane_q    <= '0;
          o_data_q  <= beat_data;
          o_strb_q  <= beat_strb;
          o_valid_q <= 1'b1;
        end else begin
          acc_q  <= beat_data;
          lane_q <= lane_q + IDX_W'(1);
          if (o_fire) begin
            o_valid_q <= 1'b0;
          end
        end
      end else if (o_fire) begin
        o_valid_q <= 1'b0;
      end
    end
  end

  assign o_valid_o = o_valid_q;
  assign o_data_o  = o_data_q;
  assign o_strb_o  = o_strb_q;
  assign busy_o    = (state_q != ST_IDLE);
  assign done_o    = (state_q == ST_DONE);
  assign beats_o   = beats_q;

endmodule
